// File: rtl/kmeans_classify_engine.sv
// kmeans_classify_engine: L1 nearest-centroid classifier feeding
// per-cluster saturating coordinate sums and point counts.
module kmeans_classify_engine #(
    parameter  int NUM_CENT = 8,
    parameter  int NUM_DIM  = 7,
    parameter  int COORD_W  = 13,
    parameter  int ACCUM_W  = 22,
    parameter  int CNT_W    = 10,
    localparam int IDX_W    = $clog2(NUM_CENT),
    localparam int PT_W     = NUM_DIM * COORD_W,
    localparam int DIST_W   = COORD_W + $clog2(NUM_DIM)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cent_wr_en,
    input  logic [IDX_W-1:0]                  cent_wr_idx,
    input  logic [PT_W-1:0]                   cent_wr_data,
    input  logic [IDX_W:0]                    k_active,
    input  logic                              pt_valid,
    output logic                              pt_ready,
    input  logic [PT_W-1:0]                   pt_data,
    input  logic                              acc_clear,
    output logic [NUM_CENT*PT_W-1:0]          cent_flat,
    output logic [NUM_CENT*NUM_DIM*ACCUM_W-1:0] acc_flat,
    output logic [NUM_CENT*CNT_W-1:0]         cnt_flat,
    output logic [IDX_W-1:0]                  last_idx,
    output logic                              busy,
    output logic                              ovf
);

    localparam logic [IDX_W:0] KMAX = (IDX_W+1)'(NUM_CENT);

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [DIST_W-1:0]  dist_t;

    coord_t             cent_q  [NUM_CENT][NUM_DIM];
    coord_t             pt_d    [NUM_DIM];
    coord_t             wr_d    [NUM_DIM];
    coord_t             p1_q    [NUM_DIM];
    coord_t             p2_q    [NUM_DIM];
    coord_t             p3_q    [NUM_DIM];
    dist_t              dist_d  [NUM_CENT];
    dist_t              dist2_q [NUM_CENT];
    dist_t              best_d;
    logic [IDX_W:0]     k_d, k1_q, k2_q;
    logic [IDX_W-1:0]   idx_d, idx3_q, last_q;
    logic [ACCUM_W-1:0] acc_q   [NUM_CENT][NUM_DIM];
    logic [ACCUM_W:0]   sum_d   [NUM_DIM];
    logic [CNT_W-1:0]   cnt_q   [NUM_CENT];
    logic [CNT_W:0]     csum_d;
    logic               v1_q, v2_q, v3_q;
    logic               ovf_q;
    logic               accept;

    assign pt_ready = !rst && !cent_wr_en && !acc_clear;
    assign accept   = pt_valid && pt_ready;

    always_comb begin
        for (int d = 0; d < NUM_DIM; d++) begin
            pt_d[d] = pt_data[d*COORD_W +: COORD_W];
            wr_d[d] = cent_wr_data[d*COORD_W +: COORD_W];
        end
    end

    always_comb begin
        k_d = k_active;
        if (k_active == '0) begin
            k_d = (IDX_W+1)'(1);
        end else if (k_active > KMAX) begin
            k_d = KMAX;
        end
    end

    // S1: L1 distance of the held point to every slot
    always_comb begin
        for (int c = 0; c < NUM_CENT; c++) begin
            dist_d[c] = '0;
            for (int d = 0; d < NUM_DIM; d++) begin
                if (p1_q[d] >= cent_q[c][d]) begin
                    dist_d[c] = dist_d[c] + DIST_W'(p1_q[d] - cent_q[c][d]);
                end else begin
                    dist_d[c] = dist_d[c] + DIST_W'(cent_q[c][d] - p1_q[d]);
                end
            end
        end
    end

    // S2: strict less-than keeps the lowest index on ties
    always_comb begin
        idx_d  = '0;
        best_d = dist2_q[0];
        for (int c = 1; c < NUM_CENT; c++) begin
            if ((IDX_W+1)'(c) < k2_q && dist2_q[c] < best_d) begin
                best_d = dist2_q[c];
                idx_d  = IDX_W'(c);
            end
        end
    end

    always_comb begin
        csum_d = {1'b0, cnt_q[idx3_q]} + (CNT_W+1)'(1);
        for (int d = 0; d < NUM_DIM; d++) begin
            sum_d[d] = {1'b0, acc_q[idx3_q][d]} + (ACCUM_W+1)'(p3_q[d]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            cent_q <= '{default: '0};
            acc_q  <= '{default: '0};
            cnt_q  <= '{default: '0};
            last_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            v1_q    <= accept;
            v2_q    <= v1_q;
            v3_q    <= v2_q;
            if (accept) begin
                p1_q <= pt_d;
                k1_q <= k_d;
            end
            p2_q    <= p1_q;
            k2_q    <= k1_q;
            dist2_q <= dist_d;
            p3_q    <= p2_q;
            idx3_q  <= idx_d;
            if (cent_wr_en && {1'b0, cent_wr_idx} < KMAX) begin
                cent_q[cent_wr_idx] <= wr_d;
            end
            if (acc_clear) begin
                acc_q  <= '{default: '0};
                cnt_q  <= '{default: '0};
                last_q <= '0;
                ovf_q  <= 1'b0;
            end else if (v3_q) begin
                for (int d = 0; d < NUM_DIM; d++) begin
                    if (sum_d[d][ACCUM_W]) begin
                        acc_q[idx3_q][d] <= '1;
                        ovf_q            <= 1'b1;
                    end else begin
                        acc_q[idx3_q][d] <= sum_d[d][ACCUM_W-1:0];
                    end
                end
                if (csum_d[CNT_W]) begin
                    cnt_q[idx3_q] <= '1;
                    ovf_q         <= 1'b1;
                end else begin
                    cnt_q[idx3_q] <= csum_d[CNT_W-1:0];
                end
                last_q <= idx3_q;
            end
        end
    end

    always_comb begin
        cent_flat = '0;
        acc_flat  = '0;
        cnt_flat  = '0;
        for (int c = 0; c < NUM_CENT; c++) begin
            cnt_flat[c*CNT_W +: CNT_W] = cnt_q[c];
            for (int d = 0; d < NUM_DIM; d++) begin
                cent_flat[(c*NUM_DIM+d)*COORD_W +: COORD_W] = cent_q[c][d];
                acc_flat[(c*NUM_DIM+d)*ACCUM_W +: ACCUM_W]  = acc_q[c][d];
            end
        end
    end

    assign last_idx = last_q;
    assign busy     = v1_q | v2_q | v3_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_kmeans_classify_engine.sv
// tb_kmeans_classify_engine: randomized scoreboard bench with a
// high-level nearest-centroid reference model.
module tb_kmeans_classify_engine;

    localparam int NC = 8;
    localparam int ND = 7;
    localparam int CW = 13;
    localparam int AW = 17;
    localparam int NW = 4;
    localparam int IW = 3;
    localparam int PW = ND * CW;
    localparam int AMAX = (1 << AW) - 1;
    localparam int CMAX = (1 << NW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cent_wr_en = 1'b0;
    logic [IW-1:0] cent_wr_idx = '0;
    logic [PW-1:0] cent_wr_data = '0;
    logic [IW:0] k_active = '0;
    logic pt_valid = 1'b0;
    logic pt_ready;
    logic [PW-1:0] pt_data = '0;
    logic acc_clear = 1'b0;
    logic [NC*PW-1:0] cent_flat;
    logic [NC*ND*AW-1:0] acc_flat;
    logic [NC*NW-1:0] cnt_flat;
    logic [IW-1:0] last_idx;
    logic busy;
    logic ovf;

    kmeans_classify_engine #(
        .NUM_CENT(NC), .NUM_DIM(ND), .COORD_W(CW),
        .ACCUM_W(AW), .CNT_W(NW)
    ) dut (
        .clk(clk), .rst(rst),
        .cent_wr_en(cent_wr_en), .cent_wr_idx(cent_wr_idx),
        .cent_wr_data(cent_wr_data), .k_active(k_active),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .acc_clear(acc_clear), .cent_flat(cent_flat),
        .acc_flat(acc_flat), .cnt_flat(cnt_flat),
        .last_idx(last_idx), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // kind: 0 point update, 1 clear, 2 reset; due = edge it takes effect
    typedef struct {
        int            kind;
        int            due;
        int            idx;
        logic [PW-1:0] pt;
    } item_t;

    item_t q[$];
    item_t keep[$];
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int mcent[NC][ND];
    int macc[NC][ND];
    int mcnt[NC];
    int mlast = 0;
    int movf = 0;
    bit m_clr, m_rst, m_hit;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int coord(input logic [PW-1:0] v, input int d);
        return int'(v[d*CW +: CW]);
    endfunction

    function automatic logic [PW-1:0] splat(input int v);
        logic [PW-1:0] r;
        for (int d = 0; d < ND; d++) r[d*CW +: CW] = CW'(v);
        return r;
    endfunction

    function automatic int nearest(input logic [PW-1:0] p, input int k);
        int kk, best, bd, dd, x;
        kk = (k == 0) ? 1 : ((k > NC) ? NC : k);
        best = 0;
        bd = -1;
        for (int c = 0; c < kk; c++) begin
            dd = 0;
            for (int d = 0; d < ND; d++) begin
                x = coord(p, d) - mcent[c][d];
                dd += (x < 0) ? -x : x;
            end
            if (bd < 0 || dd < bd) begin
                bd = dd;
                best = c;
            end
        end
        return best;
    endfunction

    task automatic check_state();
        logic [ND*AW-1:0] e;
        logic [NC*NW-1:0] ec;
        for (int c = 0; c < NC; c++) begin
            for (int d = 0; d < ND; d++) e[d*AW +: AW] = AW'(macc[c][d]);
            ec[c*NW +: NW] = NW'(mcnt[c]);
            chk($sformatf("acc[%0d]", c),
                128'(acc_flat[c*ND*AW +: ND*AW]), 128'(e));
        end
        chk("cnt", 128'(cnt_flat), 128'(ec));
        chk("last_idx", 128'(last_idx), 128'(mlast));
        chk("ovf", 128'(ovf), 128'(movf));
    endtask

    // monitor: retires scoreboard entries on the edge they are due
    always @(negedge clk) begin
        m_clr = 0;
        m_rst = 0;
        m_hit = 0;
        foreach (q[i]) begin
            if (q[i].due == cyc && q[i].kind != 0) begin
                m_clr = 1;
                if (q[i].kind == 2) m_rst = 1;
            end
        end
        keep.delete();
        foreach (q[i]) begin
            if (q[i].kind != 0) begin
                if (q[i].due != cyc) keep.push_back(q[i]);
            end else if (!(m_rst && q[i].due <= cyc + 3)) begin
                if (q[i].due == cyc) begin
                    if (!m_clr) begin
                        for (int d = 0; d < ND; d++) begin
                            macc[q[i].idx][d] += coord(q[i].pt, d);
                            if (macc[q[i].idx][d] > AMAX) begin
                                macc[q[i].idx][d] = AMAX;
                                movf = 1;
                            end
                        end
                        mcnt[q[i].idx]++;
                        if (mcnt[q[i].idx] > CMAX) begin
                            mcnt[q[i].idx] = CMAX;
                            movf = 1;
                        end
                        mlast = q[i].idx;
                        m_hit = 1;
                    end
                end else begin
                    keep.push_back(q[i]);
                end
            end
        end
        q = keep;
        if (m_clr) begin
            for (int c = 0; c < NC; c++) begin
                mcnt[c] = 0;
                for (int d = 0; d < ND; d++) macc[c][d] = 0;
            end
            mlast = 0;
            movf = 0;
        end
        if (m_clr || m_hit) check_state();
    end

    task automatic tick();
        item_t it;
        bit rdy;
        @(negedge clk);
        rdy = !rst && !cent_wr_en && !acc_clear;
        chk("pt_ready", 128'(pt_ready), 128'(rdy));
        if (pt_valid && rdy) begin
            it.kind = 0;
            it.due = cyc + 4;
            it.pt = pt_data;
            it.idx = nearest(pt_data, int'(k_active));
            q.push_back(it);
        end
        it.pt = '0;
        it.idx = 0;
        it.due = cyc + 1;
        if (rst) begin
            it.kind = 2;
            q.push_back(it);
            foreach (mcent[c, d]) mcent[c][d] = 0;
        end else begin
            if (acc_clear) begin
                it.kind = 1;
                q.push_back(it);
            end
            if (cent_wr_en && int'(cent_wr_idx) < NC) begin
                for (int d = 0; d < ND; d++) begin
                    mcent[cent_wr_idx][d] = coord(cent_wr_data, d);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cent(input int idx, input logic [PW-1:0] v);
        cent_wr_en = 1'b1;
        cent_wr_idx = IW'(idx);
        cent_wr_data = v;
        tick();
        cent_wr_en = 1'b0;
    endtask

    task automatic send(input logic [PW-1:0] p);
        pt_valid = 1'b1;
        pt_data = p;
        tick();
        pt_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_timeout", 128'(n < 60), 128'(1));
    endtask

    task automatic clear();
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        drain();
    endtask

    task automatic check_cents();
        logic [PW-1:0] e;
        for (int c = 0; c < NC; c++) begin
            for (int d = 0; d < ND; d++) e[d*CW +: CW] = CW'(mcent[c][d]);
            chk($sformatf("cent[%0d]", c),
                128'(cent_flat[c*PW +: PW]), 128'(e));
        end
    endtask

    function automatic logic [PW-1:0] rand_pt();
        logic [PW-1:0] r;
        for (int d = 0; d < ND; d++) r[d*CW +: CW] = CW'($urandom_range(0, 8191));
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        foreach (mcent[c, d]) mcent[c][d] = 0;
        foreach (macc[c, d]) macc[c][d] = 0;
        foreach (mcnt[c]) mcnt[c] = 0;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_cnt", 128'(cnt_flat), 128'(0));
        chk("rst_acc", 128'(|acc_flat), 128'(0));
        chk("rst_cent", 128'(|cent_flat), 128'(0));
        chk("rst_last", 128'(last_idx), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ovf", 128'(ovf), 128'(0));
        chk("rst_ready", 128'(pt_ready), 128'(0));
        rst = 1'b0;
        tick();

        // basic two-cluster
        k_active = 4'd2;
        wr_cent(0, splat(0));
        wr_cent(1, splat(100));
        check_cents();
        send(splat(10));
        send(splat(90));
        drain();

        // ties and k_active clamping
        clear();
        wr_cent(0, splat(50));
        wr_cent(1, splat(50));
        wr_cent(2, splat(51));
        send(splat(51));
        k_active = 4'd0;
        send(splat(51));
        k_active = 4'd3;
        send(splat(51));
        k_active = 4'd15;
        send(splat(3));
        drain();

        // back-to-back random batches
        for (int b = 0; b < 5; b++) begin
            clear();
            for (int c = 0; c < NC; c++) wr_cent(c, rand_pt());
            check_cents();
            k_active = (IW+1)'($urandom_range(0, 15));
            pt_valid = 1'b1;
            for (int i = 0; i < 40; i++) begin
                pt_data = rand_pt();
                tick();
            end
            pt_valid = 1'b0;
            n = 0;
            while (busy && n < 10) begin
                tick();
                n++;
            end
            chk("busy_fall", 128'(n), 128'(3));
            drain();
        end

        // saturation of counter and accumulator
        clear();
        k_active = 4'd1;
        wr_cent(0, splat(8191));
        for (int i = 0; i < 17; i++) send(splat(8191));
        drain();
        chk("sat_ovf", 128'(ovf), 128'(1));
        clear();

        // hazards: write blocks accept, clear beats S3, reset drops
        k_active = 4'd4;
        pt_valid = 1'b1;
        pt_data = splat(7);
        cent_wr_en = 1'b1;
        cent_wr_idx = 3'd3;
        cent_wr_data = splat(7);
        tick();
        cent_wr_en = 1'b0;
        pt_valid = 1'b0;
        check_cents();
        drain();
        send(splat(1));
        send(splat(2));
        tick();
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        drain();
        send(splat(300));
        send(splat(400));
        send(splat(500));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cents();
        send(splat(20));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
